// File: rtl/ioctl_initiator.sv
// Host-side ioctl initiator: frames one download or upload per command, moving bytes
// between valid/ready streams and the ioctl responder interface.
module ioctl_initiator #(
    parameter int ADDR_W = 25,
    parameter int WR_GAP = 1,
    parameter int RD_LAT = 2
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [7:0]        cmd_index,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        m_data,
    output logic              ioctl_download,
    output logic              ioctl_upload,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_din,
    output logic [7:0]        ioctl_index,
    input  logic              ioctl_wait,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DL_TAKE  = 3'd1,
        DL_WR    = 3'd2,
        DL_GAP   = 3'd3,
        UL_SETUP = 3'd4,
        UL_HOLD  = 3'd5,
        FINISH   = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] ONE      = 1;
    localparam logic [3:0]        GAP_LOAD = (WR_GAP > 0) ? 4'(WR_GAP - 1) : 4'd0;
    localparam logic [3:0]        LAT_LOAD = 4'(RD_LAT);

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              dl_q, dl_d;
    logic              ul_q, ul_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [7:0]        dout_q, dout_d;
    logic [7:0]        index_q, index_d;
    logic [3:0]        tmr_q, tmr_d;
    logic              m_valid_q, m_valid_d;
    logic [7:0]        m_data_q, m_data_d;
    logic              done_q, done_d;
    logic              last_byte;

    // The address doubles as the byte counter: it equals the number of bytes already moved.
    assign last_byte = (addr_q + ONE) == len_q;

    always_comb begin
        state_d   = state_q;
        dl_d      = dl_q;
        ul_d      = ul_q;
        addr_d    = addr_q;
        len_d     = len_q;
        dout_d    = dout_q;
        index_d   = index_q;
        tmr_d     = tmr_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    index_d = cmd_index;
                    len_d   = cmd_len;
                    addr_d  = '0;
                    if (cmd_len == '0) begin
                        state_d = FINISH;
                    end else if (!cmd_dir) begin
                        dl_d    = 1'b1;
                        state_d = DL_TAKE;
                    end else begin
                        ul_d    = 1'b1;
                        tmr_d   = LAT_LOAD;
                        state_d = UL_SETUP;
                    end
                end
            end
            DL_TAKE: begin
                if (s_valid && s_ready) begin
                    dout_d  = s_data;
                    state_d = DL_WR;
                end
            end
            DL_WR: begin
                if (last_byte) begin
                    state_d = FINISH;
                end else begin
                    addr_d = addr_q + ONE;
                    if (WR_GAP == 0) begin
                        state_d = DL_TAKE;
                    end else begin
                        tmr_d   = GAP_LOAD;
                        state_d = DL_GAP;
                    end
                end
            end
            DL_GAP: begin
                if (tmr_q == 4'd0) state_d = DL_TAKE;
                else               tmr_d   = tmr_q - 4'd1;
            end
            UL_SETUP: begin
                // Sample on the edge where the latency count reaches zero.
                if (!ioctl_wait) begin
                    if (tmr_q <= 4'd1) begin
                        tmr_d     = 4'd0;
                        m_data_d  = ioctl_din;
                        m_valid_d = 1'b1;
                        state_d   = UL_HOLD;
                    end else begin
                        tmr_d = tmr_q - 4'd1;
                    end
                end
            end
            UL_HOLD: begin
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    if (last_byte) begin
                        state_d = FINISH;
                    end else begin
                        addr_d  = addr_q + ONE;
                        tmr_d   = LAT_LOAD;
                        state_d = UL_SETUP;
                    end
                end
            end
            FINISH: begin
                dl_d    = 1'b0;
                ul_d    = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            dl_q        <= 1'b0;
            ul_q        <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            dout_q      <= '0;
            index_q     <= '0;
            tmr_q       <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            dl_q        <= dl_d;
            ul_q        <= ul_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            dout_q      <= dout_d;
            index_q     <= index_d;
            tmr_q       <= tmr_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign s_ready        = (state_q == DL_TAKE) && !ioctl_wait;
    assign m_valid        = m_valid_q;
    assign m_data         = m_data_q;
    assign ioctl_download = dl_q;
    assign ioctl_upload   = ul_q;
    assign ioctl_wr       = (state_q == DL_WR);
    assign ioctl_addr     = addr_q;
    assign ioctl_dout     = dout_q;
    assign ioctl_index    = index_q;
    assign done           = done_q;

endmodule

// File: tb/tb_ioctl_initiator.sv
// Directed + randomized bench for ioctl_initiator against a transfer-level reference model.
module tb_ioctl_initiator;

    localparam int AW     = 25;
    localparam int WR_GAP = 1;
    localparam int RD_LAT = 2;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_dir;
    logic [7:0]    cmd_index;
    logic [AW-1:0] cmd_len;
    logic          s_valid, s_ready;
    logic [7:0]    s_data;
    logic          m_valid, m_ready;
    logic [7:0]    m_data;
    logic          ioctl_download, ioctl_upload, ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout, ioctl_din, ioctl_index;
    logic          ioctl_wait, done;

    logic [7:0]    ram [0:1023];
    int            vectors = 0;
    int            miscompares = 0;

    always #5 clk_sys = ~clk_sys;

    assign ioctl_din = ram[ioctl_addr[9:0]];

    ioctl_initiator #(.ADDR_W(AW), .WR_GAP(WR_GAP), .RD_LAT(RD_LAT)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_index(cmd_index), .cmd_len(cmd_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
        .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 0);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_download"}, ioctl_download, 0);
        check({tag, "_upload"}, ioctl_upload, 0);
        check({tag, "_wr"}, ioctl_wr, 0);
        check({tag, "_addr"}, ioctl_addr, 0);
        check({tag, "_dout"}, ioctl_dout, 0);
        check({tag, "_index"}, ioctl_index, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic start_cmd(input bit dir, input logic [7:0] idx, input int len);
        int w = 0;
        while (!cmd_ready && w < 20) begin
            @(posedge clk_sys); #1;
            w++;
        end
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_index = idx;
        cmd_len   = AW'(len);
        @(posedge clk_sys); #1;
        cmd_valid = 1'b0;
    endtask

    // Download model: byte i of the stream must be strobed at address i.
    task automatic run_dl(input int len, input int stall_at, input int abort_at, input bit rnd_valid);
        logic [7:0] bytes [$];
        logic [7:0] idx;
        int  taken = 0, wrs = 0, last_wr = -100, cyc = 0, stall_left = 0;
        bit  saw_done = 0, prev_stall = 0;
        idx = 8'($urandom);
        for (int i = 0; i < len; i++) bytes.push_back(8'($urandom));
        start_cmd(1'b0, idx, len);
        while (cyc < 400) begin
            if (done) begin
                saw_done = 1;
                check("dl_done_download_low", ioctl_download, 0);
                check("dl_byte_count", wrs, len);
                check("dl_last_addr", ioctl_addr, len - 1);
                break;
            end
            check("dl_framing", ioctl_download, 1);
            check("dl_no_upload", ioctl_upload, 0);
            check("dl_index", ioctl_index, idx);
            if (prev_stall) check("dl_no_wr_in_stall", ioctl_wr, 0);
            if (ioctl_wr) begin
                check("dl_addr", ioctl_addr, wrs);
                check("dl_dout", ioctl_dout, bytes[wrs]);
                if (!rnd_valid && stall_at < 0 && wrs > 0)
                    check("dl_wr_spacing", cyc - last_wr, WR_GAP + 2);
                last_wr = cyc;
                wrs++;
                if (wrs == stall_at) stall_left = 7;
                if (wrs == abort_at) return;
            end
            ioctl_wait = (stall_left > 0);
            s_valid    = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data     = (taken < len) ? bytes[taken] : 8'h00;
            #1;
            if (ioctl_wait) check("dl_stall_s_ready", s_ready, 0);
            if (s_valid && s_ready) taken++;
            prev_stall = ioctl_wait;
            if (stall_left > 0) stall_left--;
            @(posedge clk_sys); #1;
            cyc++;
        end
        check("dl_done_seen", saw_done, 1);
        s_valid    = 1'b0;
        ioctl_wait = 1'b0;
    endtask

    // Upload model: the k-th byte delivered must be RAM[k], read at address k.
    task automatic run_ul(input int len, input int hold_byte, input int hold_cycles);
        logic [7:0] idx, tmp;
        int  rcv = 0, cyc = 0, held = 0, hs_cyc = 0;
        bit  saw_done = 0, prev_hs = 0, seen = 0;
        idx = 8'($urandom);
        for (int i = 0; i < len; i++) begin
            tmp    = 8'($urandom);
            ram[i] = {tmp[7:4], 4'(i)};
        end
        start_cmd(1'b1, idx, len);
        while (cyc < 400) begin
            if (done) begin
                saw_done = 1;
                check("ul_done_upload_low", ioctl_upload, 0);
                check("ul_byte_count", rcv, len);
                check("ul_last_addr", ioctl_addr, len - 1);
                break;
            end
            check("ul_framing", ioctl_upload, 1);
            check("ul_no_download", ioctl_download, 0);
            check("ul_index", ioctl_index, idx);
            if (prev_hs) check("ul_single_valid", m_valid, 0);
            m_ready = 1'b1;
            if (m_valid) begin
                check("ul_data", m_data, ram[rcv]);
                check("ul_addr", ioctl_addr, rcv);
                if (!seen) begin
                    if (rcv == 0) check("ul_first_latency", cyc, RD_LAT);
                    else          check("ul_byte_spacing", cyc - hs_cyc, RD_LAT + 1);
                    seen = 1;
                end
                if (rcv == hold_byte && held < hold_cycles) begin
                    m_ready = 1'b0;
                    held++;
                end
            end
            prev_hs = m_valid && m_ready;
            if (prev_hs) begin
                rcv++;
                hs_cyc = cyc;
                seen   = 0;
            end
            @(posedge clk_sys); #1;
            cyc++;
        end
        check("ul_done_seen", saw_done, 1);
        m_ready = 1'b1;
    endtask

    task automatic run_zero(input bit dir);
        start_cmd(dir, 8'($urandom), 0);
        check("zero_done_early", done, 0);
        check("zero_download_a", ioctl_download, 0);
        check("zero_upload_a", ioctl_upload, 0);
        check("zero_busy", cmd_ready, 0);
        @(posedge clk_sys); #1;
        check("zero_done_pulse", done, 1);
        check("zero_no_wr", ioctl_wr, 0);
        check("zero_download_b", ioctl_download, 0);
        check("zero_upload_b", ioctl_upload, 0);
        check("zero_back_idle", cmd_ready, 1);
        @(posedge clk_sys); #1;
        check("zero_done_single", done, 0);
    endtask

    initial begin
        reset = 1'b0;
        cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_index = '0; cmd_len = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b1; ioctl_wait = 1'b0;
        for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
        #2;
        check_all_zero("reset");
        @(posedge clk_sys); #1;
        check("reset_hold_cmd_ready", cmd_ready, 0);
        reset = 1'b1;
        @(posedge clk_sys); #1;
        check("release_cmd_ready", cmd_ready, 1);

        run_dl(4, -1, -1, 1'b0);
        run_ul(3, -1, 0);
        run_dl(5, 2, -1, 1'b0);
        run_ul(4, 1, 4);
        run_zero(1'b0);
        run_zero(1'b1);
        for (int t = 0; t < 4; t++) begin
            if ($urandom_range(0, 1) == 0) run_dl($urandom_range(1, 8), -1, -1, 1'b1);
            else                           run_ul($urandom_range(1, 8), $urandom_range(0, 7), $urandom_range(0, 3));
        end

        run_dl(6, -1, 2, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("abort");
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_sys); #1;
            check("abort_no_done", done, 0);
            check("abort_no_wr", ioctl_wr, 0);
        end
        reset = 1'b1;
        @(posedge clk_sys); #1;
        check("abort_release_ready", cmd_ready, 1);
        check("abort_release_done", done, 0);
        run_ul(1, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
